// File: rtl/cache_pmem_arbiter_if.sv
// cache_pmem_arbiter_if: cache-side and adaptor-side signals of the
// physical-memory arbiter, bundled so the arbiter and its environment share
// one definition.
//   slave  : arbiter view (takes cache requests, drives the adaptor)
//   master : environment view (caches plus cacheline adaptor)
interface cache_pmem_arbiter_if #(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32
);
  // I-cache side
  logic                  i_pmem_read_i;
  logic [ADDR_WIDTH-1:0] i_pmem_address_i;
  logic [LINE_WIDTH-1:0] i_pmem_rdata_o;
  logic                  i_pmem_resp_o;
  // D-cache side
  logic                  d_pmem_read_i;
  logic                  d_pmem_write_i;
  logic [ADDR_WIDTH-1:0] d_pmem_address_i;
  logic [LINE_WIDTH-1:0] d_pmem_wdata_i;
  logic [LINE_WIDTH-1:0] d_pmem_rdata_o;
  logic                  d_pmem_resp_o;
  // cacheline adaptor side
  logic                  mem_read_o;
  logic                  mem_write_o;
  logic [ADDR_WIDTH-1:0] mem_address_o;
  logic [LINE_WIDTH-1:0] mem_wdata_o;
  logic [LINE_WIDTH-1:0] mem_rdata_i;
  logic                  mem_resp_i;

  modport slave (
    input  i_pmem_read_i, i_pmem_address_i,
    input  d_pmem_read_i, d_pmem_write_i, d_pmem_address_i, d_pmem_wdata_i,
    input  mem_rdata_i, mem_resp_i,
    output i_pmem_rdata_o, i_pmem_resp_o,
    output d_pmem_rdata_o, d_pmem_resp_o,
    output mem_read_o, mem_write_o, mem_address_o, mem_wdata_o
  );

  modport master (
    output i_pmem_read_i, i_pmem_address_i,
    output d_pmem_read_i, d_pmem_write_i, d_pmem_address_i, d_pmem_wdata_i,
    output mem_rdata_i, mem_resp_i,
    input  i_pmem_rdata_o, i_pmem_resp_o,
    input  d_pmem_rdata_o, d_pmem_resp_o,
    input  mem_read_o, mem_write_o, mem_address_o, mem_wdata_o
  );
endinterface

// File: rtl/cache_pmem_arbiter.sv
// cache_pmem_arbiter: shares the single cacheline-wide physical-memory port
// between the I-cache miss path and the D-cache miss/writeback path.
// One requester is granted at a time; the grant is held until the adaptor
// responds, followed by one RECOVER cycle so a stale request cannot be
// granted again.
// Optional build macro PMEM_ARB_ROUND_ROBIN_EN: on a collision, grant the
// requester not served last. Without it the D-cache always wins a collision.

// Protocol checker: a D-cache read and writeback must never be requested
// together.
module cache_pmem_arbiter_chk (
  input logic clk,
  input logic rst,
  input logic d_read,
  input logic d_write
);
  a_d_rw_exclusive: assert property (@(posedge clk) disable iff (rst) !(d_read && d_write))
    else $error("cache_pmem_arbiter: d_pmem_read_i and d_pmem_write_i both high");
endmodule

module cache_pmem_arbiter #(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32
) (
  input logic                  clk,
  input logic                  rst,
  cache_pmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RECOVER = 2'd3
  } state_t;

  state_t                r_state;
  logic                  r_mem_read;
  logic                  r_mem_write;
  logic [ADDR_WIDTH-1:0] r_mem_address;
  logic [LINE_WIDTH-1:0] r_mem_wdata;
`ifdef PMEM_ARB_ROUND_ROBIN_EN
  logic                  r_last_grant;   // 1'b0 = I served last, 1'b1 = D served last
`endif

  logic w_d_req;
  logic w_pick_d;
  logic w_i_resp;
  logic w_d_resp;

  // Arbitration decision taken while IDLE.
  always_comb begin
    w_d_req  = bus.d_pmem_read_i | bus.d_pmem_write_i;
`ifdef PMEM_ARB_ROUND_ROBIN_EN
    w_pick_d = w_d_req & (~bus.i_pmem_read_i | ~r_last_grant);
`else
    w_pick_d = w_d_req;
`endif
  end

  // Arbiter FSM; captures the winner's command so the adaptor sees a stable
  // request for the whole grant regardless of what the requester does.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_address <= {ADDR_WIDTH{1'b0}};
      r_mem_wdata   <= {LINE_WIDTH{1'b0}};
`ifdef PMEM_ARB_ROUND_ROBIN_EN
      r_last_grant  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_d) begin
            // a read+write collision is a protocol error; the writeback wins
            r_state       <= GRANT_D;
            r_mem_read    <= ~bus.d_pmem_write_i;
            r_mem_write   <= bus.d_pmem_write_i;
            r_mem_address <= bus.d_pmem_address_i;
            r_mem_wdata   <= bus.d_pmem_wdata_i;
`ifdef PMEM_ARB_ROUND_ROBIN_EN
            r_last_grant  <= 1'b1;
`endif
          end else if (bus.i_pmem_read_i) begin
            r_state       <= GRANT_I;
            r_mem_read    <= 1'b1;
            r_mem_write   <= 1'b0;
            r_mem_address <= bus.i_pmem_address_i;
`ifdef PMEM_ARB_ROUND_ROBIN_EN
            r_last_grant  <= 1'b0;
`endif
          end else begin
            r_state     <= IDLE;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
          end
        end
        GRANT_I, GRANT_D: begin
          if (bus.mem_resp_i) begin
            r_state     <= RECOVER;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
          end else begin
            r_state     <= r_state;
            r_mem_read  <= r_mem_read;
            r_mem_write <= r_mem_write;
          end
        end
        RECOVER: begin
          r_state     <= IDLE;
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
        end
        default: begin
          r_state     <= IDLE;
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
        end
      endcase
    end
  end

  // Route the adaptor's completion to the granted requester only.
  always_comb begin
    w_i_resp = 1'b0;
    w_d_resp = 1'b0;
    case (r_state)
      GRANT_I: w_i_resp = bus.mem_resp_i;
      GRANT_D: w_d_resp = bus.mem_resp_i;
      default: begin
        w_i_resp = 1'b0;
        w_d_resp = 1'b0;
      end
    endcase
  end

  assign bus.i_pmem_resp_o  = w_i_resp;
  assign bus.d_pmem_resp_o  = w_d_resp;
  // read data is gated so the caches never see X from an idle adaptor
  assign bus.i_pmem_rdata_o = w_i_resp ? bus.mem_rdata_i : {LINE_WIDTH{1'b0}};
  assign bus.d_pmem_rdata_o = w_d_resp ? bus.mem_rdata_i : {LINE_WIDTH{1'b0}};
  assign bus.mem_read_o     = r_mem_read;
  assign bus.mem_write_o    = r_mem_write;
  assign bus.mem_address_o  = r_mem_address;
  assign bus.mem_wdata_o    = r_mem_wdata;

  cache_pmem_arbiter_chk u_chk (
    .clk     (clk),
    .rst     (rst),
    .d_read  (bus.d_pmem_read_i),
    .d_write (bus.d_pmem_write_i)
  );

endmodule

// File: tb/tb_cache_pmem_arbiter.sv
// tb_cache_pmem_arbiter: drives both caches and the adaptor from per-requester
// transaction queues and checks every cycle against a transaction-level
// model of the arbitration rules (who wins, latency, captured command,
// response routing, RECOVER spacing, reset behaviour).
module tb_cache_pmem_arbiter;
  localparam int LW = 256;
  localparam int AW = 32;

  typedef struct {
    logic [AW-1:0] addr;
    bit            wr;
    logic [LW-1:0] wdata;
    logic [LW-1:0] rdata;
    int            lat;
    bit            perturb;
    logic [AW-1:0] paddr;
  } txn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_pmem_arbiter_if #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) bus ();
  cache_pmem_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  txn_t q_i[$];
  txn_t q_d[$];
  bit   m_last_d = 1'b0;   // model: 1 when D was the last requester served

  task automatic check_val(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic txn_t rand_txn(input bit is_d);
    txn_t t;
    t.addr    = $urandom & 32'hFFFF_FFE0;
    t.wr      = is_d ? 1'($urandom_range(0, 1)) : 1'b0;
    t.wdata   = rand_line();
    t.rdata   = rand_line();
    t.lat     = $urandom_range(0, 5);
    t.perturb = 1'($urandom_range(0, 1));
    t.paddr   = $urandom;
    return t;
  endfunction

  task automatic drive_i(input bit en, input txn_t t);
    bus.i_pmem_read_i = en;
    if (en) bus.i_pmem_address_i = t.addr;
  endtask

  task automatic drive_d(input bit en, input txn_t t);
    bus.d_pmem_read_i  = en & ~t.wr;
    bus.d_pmem_write_i = en & t.wr;
    if (en) begin
      bus.d_pmem_address_i = t.addr;
      bus.d_pmem_wdata_i   = t.wdata;
    end
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, "_mem_read"}, bus.mem_read_o, 1'b0);
    check_val({tag, "_mem_write"}, bus.mem_write_o, 1'b0);
    check_val({tag, "_i_resp"}, bus.i_pmem_resp_o, 1'b0);
    check_val({tag, "_d_resp"}, bus.d_pmem_resp_o, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check_quiet(tag);
    check_val({tag, "_mem_addr"}, bus.mem_address_o, 32'h0);
    check_val({tag, "_mem_wdata"}, bus.mem_wdata_o, {LW{1'b0}});
    check_val({tag, "_i_rdata"}, bus.i_pmem_rdata_o, {LW{1'b0}});
    check_val({tag, "_d_rdata"}, bus.d_pmem_rdata_o, {LW{1'b0}});
  endtask

  // command the adaptor must see while t is granted (no resp yet)
  task automatic check_cmd(input string tag, input bit is_d, input txn_t t);
    check_val({tag, "_mem_read"}, bus.mem_read_o, is_d ? !t.wr : 1'b1);
    check_val({tag, "_mem_write"}, bus.mem_write_o, is_d & t.wr);
    check_val({tag, "_mem_addr"}, bus.mem_address_o, t.addr);
    if (is_d && t.wr) check_val({tag, "_mem_wdata"}, bus.mem_wdata_o, t.wdata);
    check_val({tag, "_i_resp"}, bus.i_pmem_resp_o, 1'b0);
    check_val({tag, "_d_resp"}, bus.d_pmem_resp_o, 1'b0);
  endtask

  // Serve everything queued; a served requester re-requests in the IDLE
  // cycle, so two non-empty queues produce back-to-back collisions.
  task automatic run_queues();
    txn_t ci, cd, cur;
    bit   ai, ad, gd;
    ai = 1'b0;
    ad = 1'b0;
    @(negedge clk);
    if (q_i.size() > 0) begin ci = q_i.pop_front(); ai = 1'b1; drive_i(1'b1, ci); end
    if (q_d.size() > 0) begin cd = q_d.pop_front(); ad = 1'b1; drive_d(1'b1, cd); end
    while (ai || ad) begin
`ifdef PMEM_ARB_ROUND_ROBIN_EN
      gd = ad && (!ai || !m_last_d);
`else
      gd = ad;
`endif
      cur = gd ? cd : ci;
      // one edge after the request is sampled the command must be up
      @(negedge clk);
      bus.mem_resp_i = 1'b0;
      #1;
      check_cmd(gd ? "grant_d" : "grant_i", gd, cur);
      for (int k = 0; k < cur.lat; k++) begin
        if (k == 0 && cur.perturb) begin
          if (gd) begin
            bus.d_pmem_address_i = cur.paddr;
            bus.d_pmem_wdata_i   = rand_line();
          end else begin
            bus.i_pmem_address_i = cur.paddr;
          end
        end
        @(negedge clk);
        #1;
        check_cmd("hold", gd, cur);
      end
      bus.mem_rdata_i = cur.rdata;
      bus.mem_resp_i  = 1'b1;
      #1;
      check_val(gd ? "d_resp" : "i_resp", gd ? bus.d_pmem_resp_o : bus.i_pmem_resp_o, 1'b1);
      check_val("resp_rdata", gd ? bus.d_pmem_rdata_o : bus.i_pmem_rdata_o, cur.rdata);
      check_val("other_resp", gd ? bus.i_pmem_resp_o : bus.d_pmem_resp_o, 1'b0);
      check_val("cmd_at_resp", {bus.mem_read_o, bus.mem_write_o},
                gd ? {!cur.wr, cur.wr} : 2'b10);
      // RECOVER: requester drops, stray adaptor resp must be ignored
      @(negedge clk);
      if (gd) begin drive_d(1'b0, cd); ad = 1'b0; m_last_d = 1'b1; end
      else    begin drive_i(1'b0, ci); ai = 1'b0; m_last_d = 1'b0; end
      bus.mem_resp_i  = 1'($urandom_range(0, 1));
      bus.mem_rdata_i = rand_line();
      #1;
      check_quiet("recover");
      // IDLE: still quiet even if the other requester is waiting
      @(negedge clk);
      bus.mem_resp_i = 1'($urandom_range(0, 1));
      #1;
      check_quiet("idle");
      if (gd && q_d.size() > 0) begin cd = q_d.pop_front(); ad = 1'b1; drive_d(1'b1, cd); end
      if (!gd && q_i.size() > 0) begin ci = q_i.pop_front(); ai = 1'b1; drive_i(1'b1, ci); end
    end
    bus.mem_resp_i = 1'b0;
  endtask

  // Absolute time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    txn_t t;
    bus.i_pmem_read_i    = 1'b0;
    bus.i_pmem_address_i = 32'h0;
    bus.d_pmem_read_i    = 1'b0;
    bus.d_pmem_write_i   = 1'b0;
    bus.d_pmem_address_i = 32'h0;
    bus.d_pmem_wdata_i   = {LW{1'b0}};
    bus.mem_rdata_i      = {LW{1'b0}};
    bus.mem_resp_i       = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // I read at 0x40, response after 5 cycles
    t = rand_txn(1'b0);
    t.addr = 32'h0000_0040; t.lat = 5; t.perturb = 1'b0; t.rdata = {8{32'hDEAD_BEEF}};
    q_i.push_back(t);
    run_queues();

    // D writeback at 0x1000, A5 pattern
    t = rand_txn(1'b1);
    t.addr = 32'h0000_1000; t.wr = 1'b1; t.wdata = {32{8'hA5}}; t.lat = 3; t.perturb = 1'b0;
    q_d.push_back(t);
    run_queues();

    // simultaneous I read 0x80 and D read 0x2000
    t = rand_txn(1'b0); t.addr = 32'h0000_0080; t.perturb = 1'b0; q_i.push_back(t);
    t = rand_txn(1'b1); t.addr = 32'h0000_2000; t.wr = 1'b0; t.perturb = 1'b0; q_d.push_back(t);
    run_queues();

    // back-to-back collisions
    for (int k = 0; k < 2; k++) begin
      q_i.push_back(rand_txn(1'b0));
      q_d.push_back(rand_txn(1'b1));
    end
    run_queues();

    // mid-grant address change on the I side
    t = rand_txn(1'b0);
    t.addr = 32'h0000_0100; t.lat = 4; t.perturb = 1'b1; t.paddr = 32'h0000_FFF0;
    q_i.push_back(t);
    run_queues();

    // reset asserted in the middle of a D grant
    t = rand_txn(1'b1); t.wr = 1'b1;
    @(negedge clk);
    drive_d(1'b1, t);
    @(negedge clk);
    #1;
    check_cmd("pre_rst_grant_d", 1'b1, t);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_all_zero("rst_async");
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("rst_hold");
    drive_d(1'b0, t);
    rst      = 1'b0;
    m_last_d = 1'b0;
    t = rand_txn(1'b0); t.addr = 32'h0000_0040;
    q_i.push_back(t);
    run_queues();

    // randomized mixes
    for (int it = 0; it < 40; it++) begin
      int ni, nd;
      ni = $urandom_range(0, 2);
      nd = $urandom_range(0, 2);
      if (ni + nd == 0) ni = 1;
      for (int k = 0; k < ni; k++) q_i.push_back(rand_txn(1'b0));
      for (int k = 0; k < nd; k++) q_d.push_back(rand_txn(1'b1));
      run_queues();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
